addr_walker: RTL and testbench

//  Block-transfer address sequencer; initiator for addr_alu. Given base address
//  and beat count, issues one memory address per beat over a valid/ready port.

---
 rtl/addr_walker.sv | 133 +++++++++++++
 tb/tb_addr_walker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/addr_walker.sv
// Block-transfer address sequencer: issues one memory address per beat over a
// valid/ready port, stepping the address through an external addr_alu.

package addr_alu_types;
    typedef enum logic [1:0] {
        CMD_INC = 2'd0,
        CMD_DEC = 2'd1,
        CMD_ADD = 2'd2,
        CMD_SUB = 2'd3
    } cmd_t;
endpackage

module addr_walker #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output addr_alu_types::cmd_t  alu_cmd,
    output logic [ADDR_W-1:0]     alu_x,
    output logic [ADDR_W-1:0]     alu_y,
    input  logic [ADDR_W-1:0]     alu_z,
    input  logic                  alu_zflag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [LEN_W-1:0]   remain_r, remain_s;
    logic               wrap_err_r, wrap_err_s;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            remain_r   <= LEN_ZERO;
            wrap_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            remain_r   <= remain_s;
            wrap_err_r <= wrap_err_s;
        end
    end

    // Next-state and datapath update; abort wins over a same-cycle handshake
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        remain_s   = remain_r;
        wrap_err_s = wrap_err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_s     = base;
                    remain_s   = len;
                    wrap_err_s = 1'b0;
                    if (len == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (mem_ready) begin
                    remain_s = remain_r - LEN_ONE;
                    if (remain_r == LEN_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_STEP;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    // A zero result means the increment rolled past all-ones
                    addr_s = alu_z;
                    if (alu_zflag) begin
                        wrap_err_s = 1'b1;
                        state_s    = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign mem_valid = (state_r == ST_ISSUE);
    assign mem_addr  = addr_r;
    assign wrap_err  = wrap_err_r;
    assign alu_cmd   = addr_alu_types::CMD_INC;
    assign alu_x     = addr_r;
    assign alu_y     = {ADDR_W{1'b0}};

endmodule

// File: tb/tb_addr_walker.sv
// Randomized self-checking bench for addr_walker; an arithmetic model predicts
// the beat address list, wrap flag and completion timing of each transfer.

module tb_addr_walker;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] base;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        wrap_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    addr_alu_types::cmd_t alu_cmd;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_z;
    logic        alu_zflag;

    int n_cmp = 0;
    int n_err = 0;

    addr_walker #(.ADDR_W(16), .LEN_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base(base), .len(len), .busy(busy), .done(done), .wrap_err(wrap_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .alu_cmd(alu_cmd), .alu_x(alu_x), .alu_y(alu_y),
        .alu_z(alu_z), .alu_zflag(alu_zflag)
    );

    // Behavioural addr_alu: INC adds one, zero flag on a zero result
    assign alu_z     = (alu_cmd == addr_alu_types::CMD_INC) ? alu_x + 16'd1 : alu_x + alu_y;
    assign alu_zflag = (alu_z == 16'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 normal, 1 abort on second offered beat, 2 reset on second offered beat
    task automatic run_xfer(input logic [15:0] b, input logic [7:0] l, input int ready_pct, input int mode);
        logic [15:0] exp_q[$];
        int   avail, nexp, beats, cyc, exp_done_cyc;
        bit   wrap_exp, ended, cut, prev_hold;
        logic [15:0] prev_addr;

        avail    = 65536 - int'(b);
        nexp     = (int'(l) <= avail) ? int'(l) : avail;
        wrap_exp = (int'(l) > avail);
        exp_q.delete();
        for (int i = 0; i < nexp; i++) exp_q.push_back(b + 16'(i));
        exp_done_cyc = (l == 8'd0) ? 1 : (wrap_exp ? 2 * nexp + 1 : 2 * nexp);

        start = 1'b1; base = b; len = l; abort = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        beats = 0; cyc = 0; ended = 1'b0; cut = 1'b0; prev_hold = 1'b0; prev_addr = 16'd0;
        while (!ended && cyc < 3000) begin
            cyc++;
            check("busy_active", busy, 1);
            if (prev_hold) begin
                check("hold_valid", mem_valid, 1);
                check("hold_addr", mem_addr, prev_addr);
            end
            if (done) begin
                check("beat_count", beats, nexp);
                check("wrap_err_end", wrap_err, wrap_exp);
                if (ready_pct >= 100) check("done_cycle", cyc, exp_done_cyc);
                start = 1'b1;
                mem_ready = 1'b0;
                ended = 1'b1;
            end else begin
                mem_ready = ($urandom_range(99) < ready_pct);
                start     = ($urandom_range(3) == 0);
                abort     = 1'b0;
                if (mem_valid && beats == 1 && mode == 1) begin
                    abort = 1'b1; cut = 1'b1; ended = 1'b1;
                end
                if (mem_valid && beats == 1 && mode == 2) begin
                    reset_n = 1'b0; mem_ready = 1'b0; cut = 1'b1; ended = 1'b1;
                end
                if (mem_valid && mem_ready) begin
                    if (beats < nexp) check("beat_addr", mem_addr, exp_q[beats]);
                    else check("extra_beat", beats, nexp);
                    beats++;
                end
                prev_hold = mem_valid && !mem_ready;
                prev_addr = mem_addr;
            end
            @(negedge clk);
        end
        if (!ended) check("timeout", 0, 1);
        start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", mem_valid, 0);
        if (mode == 2) begin
            check("rst_wrap", wrap_err, 0);
            check("rst_addr", mem_addr, 0);
            reset_n = 1'b1;
        end else if (cut) begin
            check("abort_wrap", wrap_err, 0);
        end else begin
            check("wrap_sticky", wrap_err, wrap_exp);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        base = 16'd0; len = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", mem_valid, 0);
        check("rst_wrap", wrap_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("alu_cmd", alu_cmd, addr_alu_types::CMD_INC);
        check("alu_y", alu_y, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_xfer(16'h0010, 8'd3, 100, 0);
        run_xfer(16'h0010, 8'd0, 100, 0);
        run_xfer(16'h0010, 8'd2, 25, 0);
        run_xfer(16'hFFFE, 8'd4, 100, 0);
        run_xfer(16'hFFFF, 8'd1, 100, 0);
        run_xfer(16'hFFF0, 8'd16, 100, 0);
        run_xfer(16'h0010, 8'd5, 100, 1);
        run_xfer(16'h0200, 8'd6, 60, 1);
        run_xfer(16'h0010, 8'd5, 100, 2);
        run_xfer(16'h1234, 8'd3, 100, 0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] rb;
            logic [7:0]  rl;
            rb = ($urandom_range(1) == 1) ? 16'hFFFF - 16'($urandom_range(24)) : 16'($urandom);
            rl = 8'($urandom_range(40));
            run_xfer(rb, rl, ($urandom_range(1) == 1) ? 100 : 20 + $urandom_range(70), 0);
        end
        run_xfer(16'hA000, 8'd255, 100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
